// File: rtl/sram_dual_port_bridge.sv
// Shares one synchronous SRAM between the CPU instruction and data ports.
// Serves one transaction at a time and generates the per-port stall the pipeline consumes.
module sram_dual_port_bridge #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LATENCY = 1,
    parameter int RR      = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iram_en,
    input  logic [DW/8-1:0] iram_wen,
    input  logic [AW-1:0]   iram_addr,
    input  logic [DW-1:0]   iram_wdata,
    output logic [DW-1:0]   iram_rdata,
    output logic            iram_stall,
    input  logic            dram_en,
    input  logic [DW/8-1:0] dram_wen,
    input  logic [AW-1:0]   dram_addr,
    input  logic [DW-1:0]   dram_wdata,
    output logic [DW-1:0]   dram_rdata,
    output logic            dram_stall,
    output logic            sram_en,
    output logic [DW/8-1:0] sram_wen,
    output logic [AW-1:0]   sram_addr,
    output logic [DW-1:0]   sram_wdata,
    input  logic [DW-1:0]   sram_rdata
);

    localparam int BW = DW / 8;

    generate
        if (LATENCY < 1 || LATENCY > 8) begin : g_badLatency
            $error("sram_dual_port_bridge: LATENCY must be in 1..8");
        end
        if ((DW % 8) != 0) begin : g_badWidth
            $error("sram_dual_port_bridge: DW must be a multiple of 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          r_state;
    logic            r_grantData;
    logic            r_prioData;
    logic            r_isWrite;
    logic [3:0]      r_count;
    logic            r_sramEn;
    logic [BW-1:0]   r_sramWen;
    logic [AW-1:0]   r_sramAddr;
    logic [DW-1:0]   r_sramWdata;
    logic [DW-1:0]   r_holdI;
    logic [DW-1:0]   r_holdD;

    logic            w_anyReq;
    logic            w_pickData;
    logic [BW-1:0]   w_selWen;
    logic [AW-1:0]   w_selAddr;
    logic [DW-1:0]   w_selWdata;
    logic            w_respI;
    logic            w_respD;

    // r_prioData names the port that wins the next tie; in fixed mode data always wins.
    assign w_anyReq   = iram_en | dram_en;
    assign w_pickData = dram_en & (~iram_en | (RR == 0) | r_prioData);
    assign w_selWen   = w_pickData ? dram_wen   : iram_wen;
    assign w_selAddr  = w_pickData ? dram_addr  : iram_addr;
    assign w_selWdata = w_pickData ? dram_wdata : iram_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grantData <= 1'b0;
            r_prioData  <= 1'b1;
            r_isWrite   <= 1'b0;
            r_count     <= 4'd0;
            r_sramEn    <= 1'b0;
            r_sramWen   <= '0;
            r_sramAddr  <= '0;
            r_sramWdata <= '0;
            r_holdI     <= '0;
            r_holdD     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_grantData <= w_pickData;
                        r_prioData  <= ~w_pickData;
                        r_isWrite   <= |w_selWen;
                        r_sramEn    <= 1'b1;
                        r_sramWen   <= w_selWen;
                        r_sramAddr  <= w_selAddr;
                        r_sramWdata <= w_selWdata;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_sramEn  <= 1'b0;
                    r_sramWen <= '0;
                    if (r_isWrite || LATENCY == 1) begin
                        r_state <= RESP;
                    end else begin
                        r_count <= 4'(LATENCY - 1);
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_count <= r_count - 4'd1;
                    if (r_count == 4'd1) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    // A flushed read still refreshes the hold register.
                    if (!r_isWrite) begin
                        if (r_grantData) begin
                            r_holdD <= sram_rdata;
                        end else begin
                            r_holdI <= sram_rdata;
                        end
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_respI = ~rst & (r_state == RESP) & ~r_grantData;
    assign w_respD = ~rst & (r_state == RESP) &  r_grantData;

    assign iram_stall = iram_en & ~w_respI;
    assign dram_stall = dram_en & ~w_respD;
    assign iram_rdata = (w_respI & ~r_isWrite) ? sram_rdata : r_holdI;
    assign dram_rdata = (w_respD & ~r_isWrite) ? sram_rdata : r_holdD;

    assign sram_en    = r_sramEn;
    assign sram_wen   = r_sramWen;
    assign sram_addr  = r_sramAddr;
    assign sram_wdata = r_sramWdata;

endmodule

// File: tb/tb_sram_dual_port_bridge.sv
// Randomized bench for sram_dual_port_bridge across several latency/arbitration configurations.
// Each configuration has its own SRAM model and a transaction-schedule reference model.
module tb_sram_dual_port_bridge;

    localparam int NumCfg    = 4;
    localparam int RunCycles = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int doneCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [3:0] wen);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (wen[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

    generate
        for (genvar g = 0; g < NumCfg; g++) begin : g_cfg
            localparam int Lat = (g == 0) ? 1 : (g == 1) ? 1 : (g == 2) ? 3 : 4;
            localparam int Rr  = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 1 : 0;

            logic        rst;
            logic        iramEn, dramEn, iramStall, dramStall, sramEn;
            logic [3:0]  iramWen, dramWen, sramWen;
            logic [31:0] iramAddr, dramAddr, iramWdata, dramWdata, iramRdata, dramRdata;
            logic [31:0] sramAddr, sramWdata, sramRdata;

            sram_dual_port_bridge #(
                .AW(32), .DW(32), .LATENCY(Lat), .RR(Rr)
            ) dut (
                .clk        (clk),
                .rst        (rst),
                .iram_en    (iramEn),
                .iram_wen   (iramWen),
                .iram_addr  (iramAddr),
                .iram_wdata (iramWdata),
                .iram_rdata (iramRdata),
                .iram_stall (iramStall),
                .dram_en    (dramEn),
                .dram_wen   (dramWen),
                .dram_addr  (dramAddr),
                .dram_wdata (dramWdata),
                .dram_rdata (dramRdata),
                .dram_stall (dramStall),
                .sram_en    (sramEn),
                .sram_wen   (sramWen),
                .sram_addr  (sramAddr),
                .sram_wdata (sramWdata),
                .sram_rdata (sramRdata)
            );

            logic [31:0] sramMem  [16];
            logic [31:0] modelMem [16];
            logic [31:0] rdSched  [int];
            logic [31:0] holdI, holdD, readVal, mAddr, mWdata;
            logic [3:0]  mWen;
            bit          mBusy, mGrantData, mIsWrite, mPrioData, iDone, dDone;
            int          mIssueCyc, mDoneCyc;
            string       pre;

            task automatic modelReset();
                mBusy     = 1'b0;
                mPrioData = 1'b1;
                holdI     = '0;
                holdD     = '0;
                iDone     = 1'b0;
                dDone     = 1'b0;
            endtask

            task automatic newReq(output logic [3:0] wen, output logic [31:0] addr,
                                  output logic [31:0] wdata);
                wen   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                addr  = $urandom();
                wdata = $urandom();
            endtask

            // Each port behaves like a CPU: holds a request until it sees stall low, sometimes flushes.
            task automatic applyStimulus(input bit saturate);
                if (iramEn && !iDone) begin
                    if (!saturate && $urandom_range(0, 49) == 0) iramEn = 1'b0;
                end else begin
                    iramEn = saturate ? 1'b1 : ($urandom_range(0, 2) != 0);
                    if (iramEn) newReq(iramWen, iramAddr, iramWdata);
                end
                if (dramEn && !dDone) begin
                    if (!saturate && $urandom_range(0, 49) == 0) dramEn = 1'b0;
                end else begin
                    dramEn = saturate ? 1'b1 : ($urandom_range(0, 2) != 0);
                    if (dramEn) newReq(dramWen, dramAddr, dramWdata);
                end
            endtask

            task automatic sramModel(input int c);
                if (sramEn === 1'b1) begin
                    if (sramWen != 4'h0)
                        sramMem[sramAddr[5:2]] = mergeBytes(sramMem[sramAddr[5:2]], sramWdata, sramWen);
                    else
                        rdSched[c + Lat] = sramMem[sramAddr[5:2]];
                end
            endtask

            // Reference: one transaction at a time, timed from its grant cycle.
            task automatic modelStep(input int c);
                bit          issue, resp, pickData;
                logic [31:0] expI, expD;
                if (rst) begin
                    checkOutput({pre, "rst_istall"}, 32'(iramStall), 32'(iramEn));
                    checkOutput({pre, "rst_dstall"}, 32'(dramStall), 32'(dramEn));
                    modelReset();
                    sramModel(c);
                    return;
                end
                issue = mBusy && (c == mIssueCyc);
                resp  = mBusy && (c == mDoneCyc);
                checkOutput({pre, "sram_en"}, 32'(sramEn), 32'(issue));
                checkOutput({pre, "sram_wen"}, 32'(sramWen), 32'((issue && mIsWrite) ? mWen : 4'h0));
                if (issue) begin
                    checkOutput({pre, "sram_addr"}, sramAddr, mAddr);
                    if (mIsWrite) checkOutput({pre, "sram_wdata"}, sramWdata, mWdata);
                end
                checkOutput({pre, "istall"}, 32'(iramStall), 32'(iramEn & ~(resp & !mGrantData)));
                checkOutput({pre, "dstall"}, 32'(dramStall), 32'(dramEn & ~(resp & mGrantData)));
                expI = (resp && !mIsWrite && !mGrantData) ? readVal : holdI;
                expD = (resp && !mIsWrite &&  mGrantData) ? readVal : holdD;
                checkOutput({pre, "irdata"}, iramRdata, expI);
                checkOutput({pre, "drdata"}, dramRdata, expD);
                iDone = iramEn & resp & !mGrantData;
                dDone = dramEn & resp &  mGrantData;
                if (resp) begin
                    if (!mIsWrite) begin
                        if (mGrantData) holdD = readVal;
                        else            holdI = readVal;
                    end
                    mBusy = 1'b0;
                end else if (!mBusy && (iramEn || dramEn)) begin
                    if (iramEn && dramEn) pickData = (Rr == 0) ? 1'b1 : mPrioData;
                    else                  pickData = dramEn;
                    mPrioData  = !pickData;
                    mGrantData = pickData;
                    mWen       = pickData ? dramWen   : iramWen;
                    mAddr      = pickData ? dramAddr  : iramAddr;
                    mWdata     = pickData ? dramWdata : iramWdata;
                    mIsWrite   = (mWen != 4'h0);
                    mIssueCyc  = c + 1;
                    mDoneCyc   = mIsWrite ? c + 2 : c + 1 + Lat;
                    if (mIsWrite) modelMem[mAddr[5:2]] = mergeBytes(modelMem[mAddr[5:2]], mWdata, mWen);
                    else          readVal = modelMem[mAddr[5:2]];
                    mBusy = 1'b1;
                end
                sramModel(c);
            endtask

            initial begin
                pre = $sformatf("c%0d_", g);
                rst = 1'b1;
                iramEn = 1'b0; dramEn = 1'b0;
                iramWen = '0; dramWen = '0;
                iramAddr = '0; dramAddr = '0;
                iramWdata = '0; dramWdata = '0;
                sramRdata = '0;
                for (int k = 0; k < 16; k++) begin
                    sramMem[k]  = $urandom();
                    modelMem[k] = sramMem[k];
                end
                modelReset();
                for (int c = 0; c < RunCycles; c++) begin
                    @(posedge clk);
                    #1;
                    if (rdSched.exists(c)) begin
                        sramRdata = rdSched[c];
                        rdSched.delete(c);
                    end else begin
                        sramRdata = $urandom();
                    end
                    // Beyond power-up, reset is only pulsed while a read is waiting on the SRAM.
                    if (c < 3)
                        rst = 1'b1;
                    else if (c > 100 && mBusy && !mIsWrite && c > mIssueCyc && c < mDoneCyc &&
                             $urandom_range(0, 9) == 0)
                        rst = 1'b1;
                    else
                        rst = 1'b0;
                    if (c >= 3) applyStimulus(c < 300);
                    @(negedge clk);
                    modelStep(c);
                end
                doneCount++;
            end
        end
    endgenerate

    initial begin
        int waited;
        waited = 0;
        while (doneCount < NumCfg && waited < RunCycles + 200) begin
            @(posedge clk);
            waited++;
        end
        if (doneCount < NumCfg) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout done=%0d exp=%0d", doneCount, NumCfg);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
